// File: rtl/tm1638_key_reader_if.sv
// TM1638 key reader bus bundle.
// Purpose: groups the scan request/result handshake and the TM1638 pad
//          signals of the key reader into one interface.
// Signals:
//   start    request one key scan (master -> slave)
//   dio_in   synchronised DIO pad input (master -> slave)
//   out_clk  TM1638 CLK, idles high
//   strobe   TM1638 STB, active-low frame select
//   dio_out  value driven on DIO when dio_oe=1
//   dio_oe   1 = drive DIO, 0 = release
//   busy     scan in progress, through the done cycle
//   done     one-cycle completion pulse
//   raw      four scan bytes, byte0 in [7:0]
//   keys     decoded key bits
// Modports: slave = the key reader, master = the top / testbench side.
interface tm1638_key_reader_if;
  logic        start;
  logic        dio_in;
  logic        out_clk;
  logic        strobe;
  logic        dio_out;
  logic        dio_oe;
  logic        busy;
  logic        done;
  logic [31:0] raw;
  logic [7:0]  keys;

  modport slave (
    input  start, dio_in,
    output out_clk, strobe, dio_out, dio_oe, busy, done, raw, keys
  );

  modport master (
    output start, dio_in,
    input  out_clk, strobe, dio_out, dio_oe, busy, done, raw, keys
  );
endinterface

// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader.
// Purpose: sends read-key command 0x42 (LSB first), waits the device
//          turnaround, clocks in 4 scan bytes (LSB first) and presents the
//          raw bytes plus decoded key bits with a one-cycle done pulse.
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active-low
//   bus  tm1638_key_reader_if.slave (start, dio_in in; out_clk, strobe,
//        dio_out, dio_oe, busy, done, raw, keys out)
// Parameters:
//   CLK_DIV      system clocks per half period of out_clk (>= 2)
//   WAIT_CYCLES  system clocks between last command bit and first read bit
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | strobe high, waiting for start
// S_STB_SETUP | strobe low, CLK high, command bit0 presented
// S_CMD       | shifting out the 8 command bits
// S_WAIT      | DIO released, device turnaround time
// S_READ      | clocking in 32 scan bits
// S_STB_HOLD  | CLK high before strobe release; last cycle is the done cycle
module tm1638_key_reader #(
  parameter int CLK_DIV     = 50,
  parameter int WAIT_CYCLES = 200
) (
  input  logic                   clk,
  input  logic                   rst,
  tm1638_key_reader_if.slave     bus
);

  localparam int PMAX = (CLK_DIV > WAIT_CYCLES) ? CLK_DIV : WAIT_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);

  localparam logic [PW-1:0] DIV_LD  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] HOLD_LD = PW'(CLK_DIV);
  localparam logic [PW-1:0] WAIT_LD = PW'(WAIT_CYCLES - 1);
  localparam logic [7:0]    CMD_READ = 8'h42;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STB_SETUP,
    S_CMD,
    S_WAIT,
    S_READ,
    S_STB_HOLD
  } state_t;

  state_t        state;
  logic [PW-1:0] phase_cnt;
  logic [5:0]    bit_cnt;
  logic          high_phase;
  logic [31:0]   shift_q;

  logic          out_clk_q;
  logic          strobe_q;
  logic          dio_out_q;
  logic          dio_oe_q;
  logic          busy_q;
  logic          done_q;
  logic [31:0]   raw_q;
  logic [7:0]    keys_q;
  logic [7:0]    keys_dec;

  // Key b lives in bit0 of byte b, key b+4 in bit4 of byte b.
  always_comb begin
    keys_dec = '0;
    for (int b = 0; b < 4; b++) begin
      keys_dec[b]     = shift_q[8*b];
      keys_dec[b + 4] = shift_q[8*b + 4];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      phase_cnt  <= '0;
      bit_cnt    <= '0;
      high_phase <= 1'b0;
      shift_q    <= '0;
      out_clk_q  <= 1'b1;
      strobe_q   <= 1'b1;
      dio_out_q  <= 1'b1;
      dio_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      raw_q      <= '0;
      keys_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state     <= S_STB_SETUP;
            busy_q    <= 1'b1;
            strobe_q  <= 1'b0;
            out_clk_q <= 1'b1;
            dio_oe_q  <= 1'b1;
            dio_out_q <= CMD_READ[0];
            phase_cnt <= DIV_LD;
            shift_q   <= '0;
          end
        end

        S_STB_SETUP: begin
          if (phase_cnt == '0) begin
            state      <= S_CMD;
            out_clk_q  <= 1'b0;
            high_phase <= 1'b0;
            bit_cnt    <= '0;
            phase_cnt  <= DIV_LD;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end

        S_CMD: begin
          if (phase_cnt != '0) begin
            phase_cnt <= phase_cnt - 1'b1;
          end else if (!high_phase) begin
            out_clk_q  <= 1'b1;
            high_phase <= 1'b1;
            phase_cnt  <= DIV_LD;
          end else if (bit_cnt == 6'd7) begin
            state     <= S_WAIT;
            dio_oe_q  <= 1'b0;
            dio_out_q <= 1'b1;
            phase_cnt <= WAIT_LD;
          end else begin
            // New data bit appears together with the falling CLK edge.
            bit_cnt    <= bit_cnt + 1'b1;
            out_clk_q  <= 1'b0;
            high_phase <= 1'b0;
            dio_out_q  <= CMD_READ[3'(bit_cnt[2:0] + 3'd1)];
            phase_cnt  <= DIV_LD;
          end
        end

        S_WAIT: begin
          if (phase_cnt == '0) begin
            state      <= S_READ;
            out_clk_q  <= 1'b0;
            high_phase <= 1'b0;
            bit_cnt    <= '0;
            phase_cnt  <= DIV_LD;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end

        S_READ: begin
          if (phase_cnt != '0) begin
            phase_cnt <= phase_cnt - 1'b1;
          end else if (!high_phase) begin
            // Last low-phase cycle: capture just before CLK rises.
            shift_q[bit_cnt[4:0]] <= bus.dio_in;
            out_clk_q  <= 1'b1;
            high_phase <= 1'b1;
            phase_cnt  <= DIV_LD;
          end else if (bit_cnt == 6'd31) begin
            state     <= S_STB_HOLD;
            phase_cnt <= HOLD_LD;
          end else begin
            bit_cnt    <= bit_cnt + 1'b1;
            out_clk_q  <= 1'b0;
            high_phase <= 1'b0;
            phase_cnt  <= DIV_LD;
          end
        end

        S_STB_HOLD: begin
          // Counts CLK_DIV..1 with strobe low, then one extra cycle at 0
          // which is the done cycle (strobe already high, busy still high).
          if (phase_cnt == PW'(1)) begin
            strobe_q  <= 1'b1;
            done_q    <= 1'b1;
            raw_q     <= shift_q;
            keys_q    <= keys_dec;
            phase_cnt <= '0;
          end else if (phase_cnt == '0) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.out_clk = out_clk_q;
  assign bus.strobe  = strobe_q;
  assign bus.dio_out = dio_out_q;
  assign bus.dio_oe  = dio_oe_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.raw     = raw_q;
  assign bus.keys    = keys_q;

endmodule
